// File: rtl/moore_seq_det.sv
// Serial frame receiver: hunts for SYNC, shifts in DATA_W payload bits MSB first, and counts the completed frames.
// Latency: sync_found in the cycle after the last sync bit; data_valid DATA_W cycles after sync_found.
// Backpressure: none; the block consumes one bit every clock and has no stall input.
module moore_seq_det #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1011,
    parameter int                DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sync_found,
    output logic              busy,
    output logic [7:0]        frame_count
);

    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int FILL_W = $clog2(SYNC_W + 1);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The oldest bit of each window is never needed again, so only the
    // younger bits are stored; the incoming bit completes the window.
    logic [1:0]        state,     state_nxt;
    logic [SYNC_W-2:0] sr,        sr_nxt;
    logic [FILL_W-1:0] fill,      fill_nxt;
    logic [CNT_W-1:0]  cnt,       cnt_nxt;
    logic [DATA_W-2:0] shreg,     shreg_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic [7:0]        fc_nxt;
    logic [SYNC_W-1:0] window;
    logic [DATA_W-1:0] payload;

    assign window  = {sr, input_bit};
    assign payload = {shreg, input_bit};

    always_comb begin
        state_nxt = HUNT;
        sr_nxt    = sr;
        fill_nxt  = fill;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        dout_nxt  = data_out;
        fc_nxt    = frame_count;
        case (state)
            HUNT: begin
                sr_nxt = window[SYNC_W-2:0];
                if (fill != FILL_W'(SYNC_W))
                    fill_nxt = fill + FILL_W'(1);
                // fill gate stops leftover zeros from counting as received bits
                if (window == SYNC && fill >= FILL_W'(SYNC_W - 1)) begin
                    state_nxt = RECV;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = HUNT;
                end
            end
            RECV: begin
                shreg_nxt = payload[DATA_W-2:0];
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    state_nxt = DONE;
                    dout_nxt  = payload;
                    fc_nxt    = frame_count + 8'd1;
                end else begin
                    state_nxt = RECV;
                end
            end
            DONE: begin
                state_nxt = HUNT;
                sr_nxt    = '0;
                fill_nxt  = '0;
            end
            default: begin
                state_nxt = HUNT;
                sr_nxt    = '0;
                fill_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= HUNT;
            sr          <= '0;
            fill        <= '0;
            cnt         <= '0;
            shreg       <= '0;
            data_out    <= '0;
            frame_count <= '0;
            data_valid  <= 1'b0;
            sync_found  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            fill        <= fill_nxt;
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            data_out    <= dout_nxt;
            frame_count <= fc_nxt;
            // Flags are decoded from the next state so they line up with it.
            data_valid  <= (state_nxt == DONE);
            sync_found  <= (state_nxt == RECV) && (cnt_nxt == '0);
            busy        <= (state_nxt != HUNT);
        end
    end

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed bench for moore_seq_det: reset, frame reception, sync rules, gap handling, abort, and count wrap.
module tb_moore_seq_det;

    logic       clk = 1'b0;
    logic       rst;
    logic       input_bit;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sync_found;
    logic       busy;
    logic [7:0] frame_count;

    int         vectors    = 0;
    int         miscompares = 0;
    int         dv_cnt     = 0;
    logic [7:0] exp_fc     = 8'd0;

    moore_seq_det dut (
        .clk         (clk),
        .rst         (rst),
        .input_bit   (input_bit),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .sync_found  (sync_found),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b);
        input_bit = b;
        @(posedge clk);
        #1;
        if (data_valid === 1'b1) dv_cnt++;
    endtask

    task automatic bitchk(input logic b, input logic sf, input logic bz, input logic dv);
        step(b);
        chk("sync_found", 32'(sync_found), 32'(sf));
        chk("busy",       32'(busy),       32'(bz));
        chk("data_valid", 32'(data_valid), 32'(dv));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b1);
        rst = 1'b1;
        exp_fc = 8'd0;
    endtask

    // Full frame from HUNT: sync, payload MSB first, then the bit seen in DONE.
    task automatic frame(input logic [7:0] d, input logic gap);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        bitchk(1'b0, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 7; i >= 1; i--)
            bitchk(d[i], 1'b0, 1'b1, 1'b0);
        bitchk(d[0], 1'b0, 1'b1, 1'b1);
        exp_fc = exp_fc + 8'd1;
        chk("data_out",    32'(data_out),    32'(d));
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
        bitchk(gap, 1'b0, 1'b0, 1'b0);
        chk("data_out_hold", 32'(data_out), 32'(d));
    endtask

    initial begin
        logic [7:0] p;
        rst = 1'b0;
        input_bit = 1'b0;

        // Reset with input toggling.
        step(1'b1);
        step(1'b0);
        chk("rst_data_out",    32'(data_out),    32'h0);
        chk("rst_data_valid",  32'(data_valid),  32'h0);
        chk("rst_sync_found",  32'(sync_found),  32'h0);
        chk("rst_busy",        32'(busy),        32'h0);
        chk("rst_frame_count", 32'(frame_count), 32'h0);
        rst = 1'b1;
        repeat (3) bitchk(1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame.
        frame(8'hA5, 1'b0);

        // Short prefix after reset never matches.
        do_reset();
        bitchk(1'b0, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);

        // 1,1,0,1,1: detection lands on the fifth bit.
        do_reset();
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        frame(8'h3C, 1'b0);

        // Sync starting in the DONE cycle loses its first bit.
        do_reset();
        frame(8'hBB, 1'b1);
        bitchk(1'b0, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        p = 8'h12;
        for (int i = 7; i >= 0; i--)
            bitchk(p[i], 1'b0, 1'b0, 1'b0);
        chk("gap_fc_stays", 32'(frame_count), 32'd1);
        chk("gap_data_out", 32'(data_out),    32'hBB);

        // One filler bit lets the second frame through.
        do_reset();
        frame(8'hBB, 1'b0);
        frame(8'h12, 1'b0);
        chk("two_frames_fc", 32'(frame_count), 32'd2);

        // Abort mid-frame after a completed one.
        frame(8'hA5, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        bitchk(1'b0, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b0, 1'b0, 1'b0);
        bitchk(1'b1, 1'b1, 1'b1, 1'b0);
        p = 8'hF0;
        for (int i = 7; i >= 4; i--)
            bitchk(p[i], 1'b0, 1'b1, 1'b0);
        do_reset();
        chk("abort_data_valid",  32'(data_valid),  32'h0);
        chk("abort_frame_count", 32'(frame_count), 32'h0);
        chk("abort_data_out",    32'(data_out),    32'h0);
        chk("abort_busy",        32'(busy),        32'h0);
        chk("abort_sync_found",  32'(sync_found),  32'h0);
        frame(8'h81, 1'b0);

        // 256 back-to-back frames: count wraps to 0.
        do_reset();
        dv_cnt = 0;
        for (int k = 0; k < 255; k++)
            frame(8'(k * 37 + 5), 1'b0);
        chk("wrap_fc_255", 32'(frame_count), 32'd255);
        frame(8'h5A, 1'b0);
        chk("wrap_fc_0",   32'(frame_count), 32'd0);
        chk("wrap_dv_cnt", 32'(dv_cnt),      32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
